// File: rtl/ppu_sched_if.sv
// Command handshake bundle for the PPU scheduler.
// master drives the job request; slave (scheduler) returns ready.
`timescale 1ns/1ps
interface ppu_sched_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd_mode;
  logic              i_cmd_relu_en;
  logic [CNT_W-1:0]  i_cmd_tiles;
  logic [ADDR_W-1:0] i_cmd_base;

  modport master (
    output i_cmd_valid,
    output i_cmd_mode,
    output i_cmd_relu_en,
    output i_cmd_tiles,
    output i_cmd_base,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd_mode,
    input  i_cmd_relu_en,
    input  i_cmd_tiles,
    input  i_cmd_base,
    output o_cmd_ready
  );
endinterface

// File: rtl/ppu_sched.sv
// PPU scheduler: walks accumulator tiles in MAX then CALC windows of
// AD reads each, pulsing o_ppu_start per window; ends in DRAIN until
// the PPU reports finish. Ports: cmd (job handshake), i_stall,
// o_acc_rd_en/addr, o_ppu_start/mode/relu_en, i_ppu_finish, o_pass,
// o_busy/o_done/o_err. Clock i_clk, async active-low reset i_rst_n.
// Option: PPU_SCHED_TIMEOUT_EN aborts DRAIN after 256 idle cycles.
`timescale 1ns/1ps
module ppu_sched #(
  parameter int AD     = 16,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ppu_sched_if.slave        cmd,
  input  logic              i_stall,
  output logic              o_acc_rd_en,
  output logic [ADDR_W-1:0] o_acc_rd_addr,
  output logic              o_ppu_start,
  output logic [1:0]        o_ppu_mode,
  output logic              o_ppu_relu_en,
  input  logic              i_ppu_finish,
  output logic              o_pass,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int KW = (AD > 1) ? $clog2(AD) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(AD - 1);
  localparam logic [ADDR_W-1:0] AD_STEP = ADDR_W'(AD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_CALC,
    S_GAP,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic              pass_q, pass_d;
  logic              turn_q, turn_d;
  logic [1:0]        mode_q, mode_d;
  logic              relu_q, relu_d;
  logic [CNT_W-1:0]  tiles_q, tiles_d;
  logic [CNT_W-1:0]  t_q, t_d;
  logic [KW-1:0]     k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] tbase_q, tbase_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last_tile;
`ifdef PPU_SCHED_TIMEOUT_EN
  logic [7:0]        dcnt_q, dcnt_d;
`endif

  assign last_tile = (t_q == tiles_q - 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
      turn_q  <= 1'b0;
      mode_q  <= '0;
      relu_q  <= 1'b0;
      tiles_q <= '0;
      t_q     <= '0;
      k_q     <= '0;
      base_q  <= '0;
      tbase_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PPU_SCHED_TIMEOUT_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      turn_q  <= turn_d;
      mode_q  <= mode_d;
      relu_q  <= relu_d;
      tiles_q <= tiles_d;
      t_q     <= t_d;
      k_q     <= k_d;
      base_q  <= base_d;
      tbase_q <= tbase_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PPU_SCHED_TIMEOUT_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    turn_d        = turn_q;
    mode_d        = mode_q;
    relu_d        = relu_q;
    tiles_d       = tiles_q;
    t_d           = t_q;
    k_d           = k_q;
    base_d        = base_q;
    tbase_d       = tbase_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    o_ppu_start   = 1'b0;
    o_acc_rd_en   = 1'b0;
    o_acc_rd_addr = tbase_q + ADDR_W'(k_q);
`ifdef PPU_SCHED_TIMEOUT_EN
    dcnt_d        = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd.i_cmd_valid) begin
          unique case (1'b1)
            (cmd.i_cmd_mode == 2'd3): begin
              err_d = 1'b1;
            end
            (cmd.i_cmd_tiles == '0): begin
              mode_d = cmd.i_cmd_mode;
              relu_d = cmd.i_cmd_relu_en;
              done_d = 1'b1;
            end
            default: begin
              mode_d  = cmd.i_cmd_mode;
              relu_d  = cmd.i_cmd_relu_en;
              tiles_d = cmd.i_cmd_tiles;
              base_d  = cmd.i_cmd_base;
              tbase_d = cmd.i_cmd_base;
              t_d     = '0;
              k_d     = '0;
              turn_d  = 1'b0;
              pass_d  = (cmd.i_cmd_mode == 2'd0);
              state_d = S_GAP;
            end
          endcase
        end
      end

      // First GAP cycle after a window is a forced turnaround so
      // successive starts land AD+1 cycles apart.
      S_GAP: begin
        if (turn_q) begin
          turn_d = 1'b0;
        end else if (!i_stall) begin
          o_ppu_start = 1'b1;
          o_acc_rd_en = 1'b1;
          k_d         = k_q + 1'b1;
          state_d     = pass_q ? S_CALC : S_MAX;
        end
      end

      S_MAX, S_CALC: begin
        o_acc_rd_en = 1'b1;
        k_d         = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d    = '0;
          turn_d = 1'b1;
          if (last_tile) begin
            t_d     = '0;
            tbase_d = base_q;
            if (state_q == S_MAX) begin
              pass_d  = 1'b1;
              state_d = S_GAP;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            t_d     = t_q + 1'b1;
            tbase_d = tbase_q + AD_STEP;
            state_d = S_GAP;
          end
        end
      end

      S_DRAIN: begin
        if (i_ppu_finish) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
`ifdef PPU_SCHED_TIMEOUT_EN
        else if (dcnt_q == 8'hFF) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd.o_cmd_ready = (state_q == S_IDLE);
  assign o_busy          = (state_q != S_IDLE);
  assign o_pass          = pass_q;
  assign o_ppu_mode      = mode_q;
  assign o_ppu_relu_en   = relu_q;
  assign o_done          = done_q;
  assign o_err           = err_q;

endmodule

// File: tb/tb_ppu_sched.sv
// Self-checking bench for ppu_sched: job table plus scoreboard of
// expected reads/starts, and hand-written reset sequences.
`timescale 1ns/1ps
module tb_ppu_sched;
  localparam int AD     = 16;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              stall, finish;
  logic              o_acc_rd_en, o_ppu_start, o_ppu_relu_en;
  logic [ADDR_W-1:0] o_acc_rd_addr;
  logic [1:0]        o_ppu_mode;
  logic              o_pass, o_busy, o_done, o_err;

  ppu_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) cif ();

  ppu_sched #(.AD(AD), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .cmd          (cif),
    .i_stall      (stall),
    .o_acc_rd_en  (o_acc_rd_en),
    .o_acc_rd_addr(o_acc_rd_addr),
    .o_ppu_start  (o_ppu_start),
    .o_ppu_mode   (o_ppu_mode),
    .o_ppu_relu_en(o_ppu_relu_en),
    .i_ppu_finish (finish),
    .o_pass       (o_pass),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  typedef struct {
    int c;
    logic p;
  } st_t;

  typedef struct {
    logic [1:0] mode;
    logic relu;
    int tiles;
    int base;
    int stall;
    bit tog;
    bit junk;
    int fd;
    int exp_starts;
    int exp_ev;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_start = 0;
  int run = 0;
  logic [ADDR_W-1:0] rd_q[$];
  st_t st_q[$];
  st_t mon_e;
  logic [1:0] cur_mode;
  logic cur_relu;
  vec_t tv[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (o_acc_rd_en) begin
        run++;
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", o_acc_rd_addr, rd_q.pop_front());
      end else if (run != 0) begin
        chk("win_len", run, AD);
        run = 0;
      end
      if (o_ppu_start) begin
        n_start++;
        chk("start_fresh", run, 1);
        if (st_q.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          mon_e = st_q.pop_front();
          chk("start_cyc", cyc, mon_e.c);
          chk("start_pass", o_pass, mon_e.p);
          chk("ppu_mode", {o_ppu_mode, o_ppu_relu_en},
              {cur_mode, cur_relu});
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int a, s0, n, d, evc, endc, dc, ec, nd, ne, n0, c;
    logic p;
    next_cyc();
    a = cyc;
    cif.i_cmd_valid   = 1'b1;
    cif.i_cmd_mode    = v.mode;
    cif.i_cmd_relu_en = v.relu;
    cif.i_cmd_tiles   = v.tiles[CNT_W-1:0];
    cif.i_cmd_base    = v.base[ADDR_W-1:0];
    stall = (v.stall > 0);
    n0 = n_start;
    n = (v.mode == 2'd3) ? 0 : v.tiles * ((v.mode == 2'd0) ? 1 : 2);
    s0 = a + 1 + v.stall;
    if (v.mode != 2'd3) begin
      cur_mode = v.mode;
      cur_relu = v.relu;
    end
    for (int i = 0; i < n; i++) begin
      p = (v.mode == 2'd0) || (i >= v.tiles);
      st_q.push_back('{s0 + (AD + 1) * i, p});
      for (int k = 0; k < AD; k++)
        rd_q.push_back(ADDR_W'(v.base + (i % v.tiles) * AD + k));
    end
    d = s0 + (AD + 1) * (n - 1) + AD;
    if (n == 0) evc = a + 1;
    else if (v.fd >= 0) evc = d + v.fd + 1;
    else if (v.exp_ev == 2) evc = d + 256;
    else evc = d + 300;
    endc = evc + 2;
    @(negedge clk);
    chk("cmd_ready", cif.o_cmd_ready, 1);
    next_cyc();
    cif.i_cmd_valid = 1'b0;
    dc = -1; ec = -1; nd = 0; ne = 0;
    while (cyc <= endc) begin
      c = cyc;
      stall = (c <= a + v.stall) ||
              (v.tog && c > s0 && c < s0 + AD && c[0]);
      finish = (v.fd >= 0 && c == d + v.fd) || (v.junk && c == s0 + 3);
      @(negedge clk);
      if (o_done) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (o_err) begin
        ne++;
        if (ec < 0) ec = c;
      end
      if (v.exp_ev == 0 && c == evc) chk("drain_hold", o_busy, 1);
      next_cyc();
    end
    stall = 1'b0;
    finish = 1'b0;
    chk("done_cyc", dc, (v.exp_ev == 1) ? evc : -1);
    chk("done_cnt", nd, (v.exp_ev == 1) ? 1 : 0);
    chk("err_cyc", ec, (v.exp_ev == 2) ? evc : -1);
    chk("err_cnt", ne, (v.exp_ev == 2) ? 1 : 0);
    chk("starts", n_start - n0, v.exp_starts);
    chk("rd_left", rd_q.size(), 0);
    if (v.exp_ev != 0)
      chk("idle_after", {o_busy, cif.o_cmd_ready}, 2'b01);
  endtask

  task automatic reset_mid_window();
    int cnt;
    next_cyc();
    cif.i_cmd_valid   = 1'b1;
    cif.i_cmd_mode    = 2'd0;
    cif.i_cmd_relu_en = 1'b1;
    cif.i_cmd_tiles   = 8'd1;
    cif.i_cmd_base    = 10'd64;
    cur_mode = 2'd0;
    cur_relu = 1'b1;
    st_q.push_back('{cyc + 1, 1'b1});
    for (int k = 0; k < AD; k++) rd_q.push_back(ADDR_W'(64 + k));
    next_cyc();
    cif.i_cmd_valid = 1'b0;
    repeat (7) next_cyc();
    chk("pre_rst_addr", o_acc_rd_addr, 71);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", cif.o_cmd_ready, 1);
    chk("rst_mid_outs", {o_acc_rd_en, o_ppu_start, o_done, o_err,
        o_pass, o_ppu_mode, o_ppu_relu_en, o_busy}, 0);
    chk("rst_mid_addr", o_acc_rd_addr, 0);
    rd_q.delete();
    st_q.delete();
    next_cyc();
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      cnt += int'(o_acc_rd_en) + int'(o_ppu_start) + int'(o_busy);
      next_cyc();
    end
    chk("no_resume", cnt, 0);
    chk("ready_after", cif.o_cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{2'd0, 1'b1, 2, 0,    0, 1'b0, 1'b0, 3, 2, 1};
    tv[1] = '{2'd2, 1'b0, 2, 0,    0, 1'b0, 1'b0, 0, 4, 1};
    tv[2] = '{2'd0, 1'b1, 1, 1016, 0, 1'b0, 1'b0, 1, 1, 1};
    tv[3] = '{2'd1, 1'b0, 1, 5,    5, 1'b1, 1'b1, 2, 2, 1};
    tv[4] = '{2'd3, 1'b1, 3, 0,    0, 1'b0, 1'b0, 0, 0, 2};
    tv[5] = '{2'd0, 1'b0, 0, 0,    0, 1'b0, 1'b0, 0, 0, 1};
    tv[6] = '{2'd1, 1'b1, 3, 1000, 0, 1'b0, 1'b0, 0, 6, 1};
`ifdef PPU_SCHED_TIMEOUT_EN
    tv[7] = '{2'd0, 1'b0, 1, 0,    0, 1'b0, 1'b0, -1, 1, 2};
`else
    tv[7] = '{2'd0, 1'b0, 1, 0,    0, 1'b0, 1'b0, -1, 1, 0};
`endif

    cif.i_cmd_valid   = 1'b0;
    cif.i_cmd_mode    = 2'd0;
    cif.i_cmd_relu_en = 1'b0;
    cif.i_cmd_tiles   = '0;
    cif.i_cmd_base    = '0;
    stall  = 1'b0;
    finish = 1'b0;
    cur_mode = 2'd0;
    cur_relu = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", cif.o_cmd_ready, 1);
    chk("rst_outs", {o_acc_rd_en, o_ppu_start, o_done, o_err,
        o_pass, o_ppu_mode, o_ppu_relu_en, o_busy}, 0);
    next_cyc();
    rst_n = 1'b1;
    repeat (2) next_cyc();

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    if (o_busy) begin
      rst_n = 1'b0;
      next_cyc();
      rst_n = 1'b1;
      rd_q.delete();
      st_q.delete();
      next_cyc();
    end

    reset_mid_window();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ppu_sched.md
PPU_SCHED -- requirements
Module: ppu_sched

Interface
REQ-001 SHALL have parameter AD, 16, accumulator rows per tile (PPU window length in cycles).
REQ-002 SHALL have parameter ADDR_W, 10, accumulator-buffer address width.
REQ-003 SHALL have parameter CNT_W, 8, tile-count width.
REQ-004 SHALL have port i_clk  input  1  clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_cmd_valid  input  1  job request.
REQ-007 SHALL have port o_cmd_ready  output  1  job accepted when high with i_cmd_valid.
REQ-008 SHALL have port i_cmd_mode  input  2  0=INT4_VSQ, 1=INT4, 2=INT8, 3=reserved.
REQ-009 SHALL have port i_cmd_relu_en  input  1  ReLU enable for the job.
REQ-010 SHALL have port i_cmd_tiles  input  CNT_W  tile count of the matrix.
REQ-011 SHALL have port i_cmd_base  input  ADDR_W  first accumulator address.
REQ-012 SHALL have port i_stall  input  1  hold off next tile start (buffer arbitration).
REQ-013 SHALL have port o_acc_rd_en  output  1  accumulator-buffer read enable.
REQ-014 SHALL have port o_acc_rd_addr  output  ADDR_W  accumulator-buffer read address.
REQ-015 SHALL have port o_ppu_start  output  1  one-cycle PPU start pulse.
REQ-016 SHALL have port o_ppu_mode  output  2  latched job mode to PPU.
REQ-017 SHALL have port o_ppu_relu_en  output  1  latched ReLU enable to PPU.
REQ-018 SHALL have port i_ppu_finish  input  1  PPU quantizer finish pulse.
REQ-019 SHALL have port o_pass  output  1  0=MAX pass, 1=CALC pass.
REQ-020 SHALL have ports o_busy, o_done, o_err  output  1 each  busy level, done pulse, error pulse.

Function
REQ-021 SHALL implement states IDLE, MAX, CALC, GAP, DRAIN; o_cmd_ready=1 only in IDLE; o_busy=1 in every state except IDLE.
REQ-022 SHALL on accept latch mode, relu_en, tiles, base; mode 1/2 go to GAP with o_pass=0; mode 0 goes to GAP with o_pass=1.
REQ-023 SHALL with mode 3 accept the command, pulse o_err for one cycle, stay IDLE, issue no start or read.
REQ-024 SHALL with tiles=0 accept, pulse o_done the next cycle, issue no start or read.
REQ-025 GAP: SHALL assert o_ppu_start for one cycle when i_stall=0 and enter MAX/CALC per o_pass; i_stall=1 holds GAP.
REQ-026 MAX/CALC window: for tile t, o_acc_rd_en=1 for exactly AD cycles starting in the o_ppu_start cycle, address base+t*AD+k (k=0..AD-1), modulo 2^ADDR_W.
REQ-027 SHALL ignore i_stall inside a window; a window is never interrupted.
REQ-028 SHALL return to GAP after each window so consecutive starts are exactly AD+1 cycles apart with i_stall=0.
REQ-029 SHALL after the last MAX tile set o_pass=1, reset t to 0, re-read the same addresses in a CALC pass.
REQ-030 SHALL after the last CALC tile enter DRAIN; on i_ppu_finish pulse o_done one cycle and return IDLE.
REQ-031 SHALL ignore i_ppu_finish outside DRAIN; i_ppu_finish in the cycle DRAIN is entered counts.
REQ-032 o_ppu_mode/o_ppu_relu_en SHALL stay constant from accept until IDLE.

Reset
REQ-033 SHALL on i_rst_n=0 at any time (incl. mid-window) go to IDLE; o_cmd_ready=1, all other outputs 0, counters 0.
REQ-034 SHALL after reset release require a new command; no job resumes.

Configuration
REQ-035 SHALL with PPU_SCHED_TIMEOUT_EN defined count DRAIN cycles; at 256 cycles without i_ppu_finish pulse o_err, no o_done, return IDLE.
REQ-036 SHALL without PPU_SCHED_TIMEOUT_EN wait in DRAIN indefinitely; o_err only from REQ-023.

Verification
REQ-037 mode 0, tiles=2, base=0 -> starts at cycles 1,18; reads 0..15, 16..31; finish -> o_done one cycle.
REQ-038 mode 2, tiles=2, base=0 -> 4 starts, o_pass 0,0,1,1, reads 0..31 twice, then DRAIN.
REQ-039 base=1016, tiles=1, mode 0 -> addresses 1016..1023, 0..7 (wrap).
REQ-040 i_stall high 5 cycles in GAP and toggled in-window -> start delayed 5 cycles; window reads unbroken.
REQ-041 reset asserted at k=7 of a window -> all outputs 0 immediately, IDLE, o_cmd_ready=1.
REQ-042 mode 3 -> o_err one cycle, no start; tiles=0 -> o_done next cycle; with PPU_SCHED_TIMEOUT_EN no finish -> o_err after 256 DRAIN cycles.
